seq_det_arbiter: RTL and testbench

Round-robin controller that shares one serial Moore sequence detector (1101 detector, one bit per clock, registered Moore output) between N_REQ byte-wide requesters. Accepts one word at a time over valid/ready, serializes it MSB-first into the detector, counts detector hits, and flushes detector state before the next word. It reports per-word hit counts and keeps a saturating hit total for each requester. Sits between the requester logic and the detector instance.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/seq_det_arbiter.sv | 152 +++++++++++++++
 tb/tb_seq_det_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the sequence-detector arbiter slice.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_W          = 8;
    localparam int DEF_FLUSH_BITS = 2;
    localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant,
// wrapping around, wins. The last_grant register lives in the parent.
module rr_arbiter
    import seq_det_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_any
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Walk the requesters starting just after last_grant; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_grant) + k) % N_REQ;
            cand_idx = IW'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant_any       = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// Shares one serial 1101 Moore detector between N_REQ requesters: accepts a
// word, streams it MSB-first, flushes the detector, reports the hit count
// and keeps a saturating hit total per requester.
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter  int N_REQ      = 2,
    parameter  int W          = DEF_W,
    parameter  int FLUSH_BITS = DEF_FLUSH_BITS,
    parameter  int CNT_W      = DEF_CNT_W,
    localparam int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HW         = $clog2(W + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*W-1:0]     req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   det_in,
    input  logic                   det_out,
    output logic                   done_valid,
    output logic [IW-1:0]          done_id,
    output logic [HW-1:0]          done_hits,
    output logic [N_REQ*CNT_W-1:0] hit_total,
    input  logic [N_REQ-1:0]       clr,
    output logic                   busy
);

    localparam int CTR_W = $clog2(((W > FLUSH_BITS) ? W : FLUSH_BITS) + 1);

    state_t             state;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      id;
    logic [W-1:0]       shreg;
    logic [CTR_W-1:0]   cnt;
    logic [HW-1:0]      hits;
    logic [HW-1:0]      hits_next;
    logic               in_window;
    logic [CNT_W-1:0]   totals [N_REQ];
    logic [W-1:0]       req_word [N_REQ];
    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_word[i]                    = req_data[i*W +: W];
        assign hit_total[i*CNT_W +: CNT_W]    = totals[i];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    // The detector answers one cycle late, so the window runs from the second
    // shifted bit through the first flush cycle.
    assign in_window = det_out &&
                       (((state == SHIFT) && (cnt != '0)) ||
                        ((state == FLUSH) && (cnt == '0)));
    assign hits_next = in_window ? hits + HW'(1) : hits;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [HW-1:0]    b);
        logic [CNT_W+HW-1:0] s;
        s = {{HW{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (s > {{HW{1'b0}}, {CNT_W{1'b1}}})
            return '1;
        return s[CNT_W-1:0];
    endfunction

    // Word sequencing: accept, shift out MSB-first, flush, then report.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            id         <= '0;
            shreg      <= '0;
            cnt        <= '0;
            hits       <= '0;
            det_in     <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_hits  <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    det_in <= 1'b0;
                    if (grant_any) begin
                        shreg      <= req_word[grant_idx];
                        det_in     <= req_word[grant_idx][W-1];
                        id         <= grant_idx;
                        last_grant <= grant_idx;
                        hits       <= '0;
                        cnt        <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    hits <= hits_next;
                    if (cnt == CTR_W'(W - 1)) begin
                        cnt    <= '0;
                        det_in <= 1'b0;
                        state  <= FLUSH;
                    end else begin
                        cnt    <= cnt + CTR_W'(1);
                        shreg  <= shreg << 1;
                        det_in <= shreg[W-2];
                    end
                end
                FLUSH: begin
                    hits <= hits_next;
                    if (cnt == CTR_W'(FLUSH_BITS - 1)) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_id    <= id;
                        done_hits  <= hits_next;
                    end else begin
                        cnt <= cnt + CTR_W'(1);
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-requester saturating totals; a clear beats a same-cycle update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++)
                totals[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (clr[i])
                    totals[i] <= '0;
                else if ((state == DONE) && (id == IW'(i)))
                    totals[i] <= sat_add(totals[i], done_hits);
            end
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: models the external 1101 detector, predicts
// grants, hit counts and totals from the word values, and checks each step.
module tb_seq_det_arbiter;

    localparam int N_REQ = 2;
    localparam int W     = 8;
    localparam int FB    = 2;
    localparam int CNT_W = 2;
    localparam int IW    = 1;
    localparam int HW    = 4;
    localparam int MAXT  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*W-1:0]     req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   det_in;
    logic                   det_out;
    logic                   done_valid;
    logic [IW-1:0]          done_id;
    logic [HW-1:0]          done_hits;
    logic [N_REQ*CNT_W-1:0] hit_total;
    logic [N_REQ-1:0]       clr;
    logic                   busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int last_grant_m = N_REQ - 1;
    int tot_m [N_REQ];
    int last_accept  = 0;
    int dstate;

    seq_det_arbiter #(
        .N_REQ(N_REQ), .W(W), .FLUSH_BITS(FB), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .det_in     (det_in),
        .det_out    (det_out),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_hits  (done_hits),
        .hit_total  (hit_total),
        .clr        (clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // External non-overlapping 1101 Moore detector (0:none 1:"1" 2:"11" 3:"110" 4:hit).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) dstate <= 0;
        else begin
            case (dstate)
                0: dstate <= det_in ? 1 : 0;
                1: dstate <= det_in ? 2 : 0;
                2: dstate <= det_in ? 2 : 3;
                3: dstate <= det_in ? 4 : 0;
                default: dstate <= det_in ? 1 : 0;
            endcase
        end
    end
    assign det_out = (dstate == 4);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Non-overlapping left-to-right count of 1101 in the word, MSB first.
    function automatic int expHits(input logic [W-1:0] w);
        int i = 0;
        int c = 0;
        while (i <= W - 4) begin
            if (w[W-1-i] && w[W-2-i] && !w[W-3-i] && w[W-4-i]) begin
                c++;
                i += 4;
            end else begin
                i++;
            end
        end
        return c;
    endfunction

    function automatic int expGrant(input logic [N_REQ-1:0] m, input int last);
        for (int k = 1; k <= N_REQ; k++)
            if (m[(last + k) % N_REQ]) return (last + k) % N_REQ;
        return -1;
    endfunction

    function automatic int getTotal(input int i);
        logic [CNT_W-1:0] v;
        v = hit_total[i*CNT_W +: CNT_W];
        return int'(v);
    endfunction

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_req_ready"}, req_ready, 0);
        checkOutput({pfx, "_det_in"}, det_in, 0);
        checkOutput({pfx, "_done_valid"}, done_valid, 0);
        checkOutput({pfx, "_done_id"}, done_id, 0);
        checkOutput({pfx, "_done_hits"}, done_hits, 0);
        checkOutput({pfx, "_hit_total"}, hit_total, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
    endtask

    // Offer a word set at a negedge with the DUT idle and follow it to completion.
    task automatic applyStimulus(input logic [N_REQ-1:0] mask, input logic [W-1:0] d0,
                                 input logic [W-1:0] d1, input logic [N_REQ-1:0] clr_at_done);
        int g;
        int h;
        logic [W-1:0] w;
        logic exp_bit;
        req_data  = {d1, d0};
        req_valid = mask;
        g = expGrant(mask, last_grant_m);
        w = (g == 0) ? d0 : d1;
        h = expHits(w);
        #1;
        checkOutput("accept_ready", req_ready, 32'(1) << g);
        last_accept = cycle;
        @(posedge clk);
        last_grant_m = g;
        #1 req_valid = '0;
        for (int k = 0; k <= W + FB; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput("ready_low_busy", req_ready, 0);
                checkOutput("busy_high", busy, 1);
            end
            if (k < W + FB) begin
                exp_bit = (k < W) ? w[W-1-k] : 1'b0;
                checkOutput($sformatf("det_in_%0d", k), det_in, exp_bit);
                checkOutput("done_early", done_valid, 0);
            end else begin
                checkOutput("done_valid", done_valid, 1);
                checkOutput("done_id", done_id, g);
                checkOutput("done_hits", done_hits, h);
                clr = clr_at_done;
            end
        end
        @(negedge clk);
        clr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (clr_at_done[i]) tot_m[i] = 0;
            else if (i == g) tot_m[i] = (tot_m[i] + h > MAXT) ? MAXT : tot_m[i] + h;
        end
        checkOutput("done_one_cycle", done_valid, 0);
        checkOutput("busy_idle", busy, 0);
        for (int i = 0; i < N_REQ; i++)
            checkOutput($sformatf("hit_total_%0d", i), getTotal(i), tot_m[i]);
    endtask

    initial begin
        int prev;
        req_valid = '0;
        req_data  = '0;
        clr       = '0;
        for (int i = 0; i < N_REQ; i++) tot_m[i] = 0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Directed words with known hit counts.
        applyStimulus(2'b01, 8'hDB, 8'h00, 2'b00);
        applyStimulus(2'b10, 8'h00, 8'hDD, 2'b00);
        applyStimulus(2'b01, 8'h0D, 8'h00, 2'b00);
        applyStimulus(2'b10, 8'h00, 8'h00, 2'b00);

        // Flush: trailing 11 must not combine with the next word's 01.
        applyStimulus(2'b01, 8'h03, 8'h00, 2'b00);
        applyStimulus(2'b01, 8'h40, 8'h00, 2'b00);

        // Clear requester 1 while idle.
        clr = 2'b10;
        @(negedge clk);
        clr = '0;
        tot_m[1] = 0;
        checkOutput("clr_idle_1", getTotal(1), 0);
        checkOutput("clr_idle_0_kept", getTotal(0), tot_m[0]);

        // Saturation, then a clear landing on the DONE cycle.
        repeat (4) applyStimulus(2'b01, 8'hDD, 8'h00, 2'b00);
        applyStimulus(2'b01, 8'hDD, 8'h00, 2'b01);

        // Reset in the middle of a word.
        req_data  = {8'h00, 8'hDD};
        req_valid = 2'b01;
        #1 checkOutput("rst_accept_ready", req_ready, 32'(1) << expGrant(2'b01, last_grant_m));
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1 checkResetOutputs("midreset");
        last_grant_m = N_REQ - 1;
        for (int i = 0; i < N_REQ; i++) tot_m[i] = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 11) rstn = 1'b1;
            checkOutput("midreset_no_done", done_valid, 0);
        end
        @(negedge clk);

        // Both requesters valid continuously: alternating grants, 12 cycles apart.
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(2'b11, 8'($urandom), 8'($urandom), 2'b00);
            if (n == 0) prev = last_accept;
            else begin
                checkOutput("grant_spacing", last_accept - prev, 12);
                prev = last_accept;
            end
        end

        // Randomized words, masks and occasional clears.
        for (int n = 0; n < 16; n++) begin
            logic [N_REQ-1:0] m;
            logic [N_REQ-1:0] c;
            m = N_REQ'($urandom_range(1, 3));
            c = ($urandom_range(0, 5) == 0) ? N_REQ'($urandom_range(0, 3)) : '0;
            applyStimulus(m, 8'($urandom), 8'($urandom), c);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
